uart_tx: RTL and testbench

//   UART transmitter; peer of uart_rx on the same serial link. Accepts a parallel

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, framed serial bitstream out.
// Frame is start, LSB-first data, optional parity, then one or two stop bits.
module uart_tx #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_uart_tx,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_user_tx_busy
);

    localparam int BIT_CLKS = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [2:0] LAST_BIT = 3'(P_UART_DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(P_UART_STOP_WIDTH - 1);

    if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 8) begin : g_bad_dw
        $error("uart_tx: P_UART_DATA_WIDTH must be 5..8");
    end
    if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_bad_sw
        $error("uart_tx: P_UART_STOP_WIDTH must be 1..2");
    end
    if (P_UART_CHECK < 0 || P_UART_CHECK > 2) begin : g_bad_chk
        $error("uart_tx: P_UART_CHECK must be 0..2");
    end
    if (BIT_CLKS < 2) begin : g_bad_baud
        $error("uart_tx: bit period must be at least 2 clocks");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                       state_q;
    logic [CW-1:0]                baud_q;
    logic [CW-1:0]                baud_d;
    logic [2:0]                   bit_q;
    logic                         stop_q;
    logic [P_UART_DATA_WIDTH-1:0] shreg_q;
    logic                         par_q;
    logic                         par_d;
    logic                         tx_q;
    logic                         ready_q;
    logic                         busy_q;
    logic                         bit_end;

    always_comb begin
        bit_end = (baud_q == LAST);
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        par_d   = (P_UART_CHECK == 2) ? ^i_user_tx_data
                                      : ~^i_user_tx_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (i_user_tx_valid && ready_q) begin
                        shreg_q <= i_user_tx_data;
                        par_q   <= par_d;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (bit_q == LAST_BIT) begin
                            stop_q <= 1'b0;
                            if (P_UART_CHECK != 0) begin
                                state_q <= PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                    end
                end
                STOP: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (stop_q == LAST_STOP) begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_uart_tx       = tx_q;
    assign o_user_tx_ready = ready_q;
    assign o_user_tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no parity, even, odd
// and two stop bits at a 10-clock bit period.
module tb_uart_tx;

    localparam int CLK  = 1_000_000;
    localparam int BAUD = 100_000;
    localparam int BC   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic [3:0] tx;
    logic [3:0] ready;
    logic [3:0] busy;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .P_SYSTEM_CLK(CLK), .P_UART_BUADRATE(BAUD),
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1),
        .P_UART_CHECK(0)
    ) u_none (
        .i_clk(clk), .i_rst(rst), .o_uart_tx(tx[0]),
        .i_user_tx_data(data[0]), .i_user_tx_valid(valid[0]),
        .o_user_tx_ready(ready[0]), .o_user_tx_busy(busy[0])
    );

    uart_tx #(
        .P_SYSTEM_CLK(CLK), .P_UART_BUADRATE(BAUD),
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1),
        .P_UART_CHECK(2)
    ) u_even (
        .i_clk(clk), .i_rst(rst), .o_uart_tx(tx[1]),
        .i_user_tx_data(data[1]), .i_user_tx_valid(valid[1]),
        .o_user_tx_ready(ready[1]), .o_user_tx_busy(busy[1])
    );

    uart_tx #(
        .P_SYSTEM_CLK(CLK), .P_UART_BUADRATE(BAUD),
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1),
        .P_UART_CHECK(1)
    ) u_odd (
        .i_clk(clk), .i_rst(rst), .o_uart_tx(tx[2]),
        .i_user_tx_data(data[2]), .i_user_tx_valid(valid[2]),
        .o_user_tx_ready(ready[2]), .o_user_tx_busy(busy[2])
    );

    uart_tx #(
        .P_SYSTEM_CLK(CLK), .P_UART_BUADRATE(BAUD),
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2),
        .P_UART_CHECK(0)
    ) u_stop2 (
        .i_clk(clk), .i_rst(rst), .o_uart_tx(tx[3]),
        .i_user_tx_data(data[3]), .i_user_tx_valid(valid[3]),
        .o_user_tx_ready(ready[3]), .o_user_tx_busy(busy[3])
    );

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge
    // of the first start-bit cycle with valid dropped.
    task automatic send(input int w, input logic [7:0] d);
        valid[w] = 1'b1;
        data[w]  = d;
        @(negedge clk);
        valid[w] = 1'b0;
    endtask

    // Bit i of bits is the i-th level on the line, each BC clocks long.
    task automatic expect_frame(input int w, input logic [11:0] bits,
                                input int nb);
        for (int c = 0; c < nb * BC; c++) begin
            chk($sformatf("tx%0d_c%0d", w, c), 12'(tx[w]),
                12'(bits[c / BC]));
            chk($sformatf("rdy%0d_c%0d", w, c), 12'(ready[w]), 12'd0);
            chk($sformatf("busy%0d_c%0d", w, c), 12'(busy[w]), 12'd1);
            @(negedge clk);
        end
        chk($sformatf("idle_tx%0d", w), 12'(tx[w]), 12'd1);
        chk($sformatf("idle_rdy%0d", w), 12'(ready[w]), 12'd1);
        chk($sformatf("idle_busy%0d", w), 12'(busy[w]), 12'd0);
    endtask

    initial begin
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;

        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 12'(tx), 12'hF);
            chk("rst_rdy", 12'(ready), 12'hF);
            chk("rst_busy", 12'(busy), 12'h0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_tx", 12'(tx), 12'hF);
        chk("post_rst_rdy", 12'(ready), 12'hF);
        chk("post_rst_busy", 12'(busy), 12'h0);

        send(0, 8'h55);
        expect_frame(0, {2'b00, 1'b1, 8'h55, 1'b0}, 10);

        @(negedge clk);
        send(1, 8'h07);
        expect_frame(1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);

        @(negedge clk);
        send(2, 8'h07);
        expect_frame(2, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);

        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        @(negedge clk);
        data[0]  = 8'h3C;
        expect_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
        @(negedge clk);
        valid[0] = 1'b0;
        expect_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);

        @(negedge clk);
        send(3, 8'hFF);
        expect_frame(3, {1'b0, 2'b11, 8'hFF, 1'b0}, 11);

        @(negedge clk);
        send(0, 8'h00);
        repeat (35) @(negedge clk);
        chk("mid_tx_low", 12'(tx[0]), 12'd0);
        chk("mid_busy", 12'(busy[0]), 12'd1);
        rst = 1'b1;
        #1;
        chk("abort_tx", 12'(tx[0]), 12'd1);
        chk("abort_rdy", 12'(ready[0]), 12'd1);
        chk("abort_busy", 12'(busy[0]), 12'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk("no_retx_tx", 12'(tx), 12'hF);
            chk("no_retx_rdy", 12'(ready), 12'hF);
        end
        send(0, 8'h00);
        expect_frame(0, {2'b00, 1'b1, 8'h00, 1'b0}, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
